uart_8250_tx_engine: RTL and testbench

Transmit datapath behind the uart_8250 Wishbone register file.
- Buffers bytes written to THR in a 16-entry FIFO.
- Generates the 16x baud timing from the DLL/DLM divisor.
- Serialises each byte onto txd according to the LCR framing fields.
- Returns THRE/TEMT status to the register block for LSR and interrupt generation.

---
 rtl/uart_8250_tx_engine.sv | 217 +++++++++++++++++++++
 tb/tb_uart_8250_tx_engine.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_8250_tx_engine.sv
// Transmit side of the 8250-style UART: a THR FIFO, a 16x baud tick generator and a framing FSM
// that serialises each byte onto txd. THRE/TEMT and the full flag feed the register block.
module uart_8250_tx_engine #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [15:0] divisor,
  input  logic [6:0]  lcr,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        fifo_reset,
  output logic        fifo_full,
  output logic        thre,
  output logic        temt,
  output logic        txd
);

  // Write handshake: wr_en is a one-cycle strobe with no ready; a strobe seen while
  // fifo_full is high is discarded, so the writer must respect fifo_full itself.

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

  state_t               r_state;
  state_t               w_state_next;

  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr;
  logic [FIFO_AW-1:0]   r_rd_ptr;
  logic [FIFO_AW:0]     r_count;
  logic [FIFO_AW:0]     w_count_next;
  logic                 w_push;
  logic                 w_load;

  logic                 r_full;
  logic                 r_thre;
  logic                 r_temt;
  logic                 r_txd;
  logic                 w_txd_next;

  logic [15:0]          r_div;
  logic [15:0]          r_baud_cnt;
  logic                 w_tick;
  logic                 w_div_ok;

  logic [3:0]           r_lcr;
  logic [7:0]           r_shift;
  logic                 r_parity;
  logic [5:0]           r_tick_cnt;
  logic [2:0]           r_bit_cnt;
  logic [5:0]           w_seg_ticks;
  logic                 w_seg_done;
  logic                 w_last_bit;

  logic [7:0]           w_head;
  logic [7:0]           w_mask;
  logic                 w_head_parity;

  assign w_div_ok     = (divisor != 16'd0);
  assign w_push       = wr_en && !r_full && !fifo_reset;
  assign w_count_next = fifo_reset ? '0
                      : r_count + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_load};

  assign w_head        = r_mem[r_rd_ptr];
  assign w_mask        = 8'hFF >> (2'd3 - lcr[1:0]);
  assign w_head_parity = lcr[5] ? ~lcr[4]
                       : (lcr[4] ? ^(w_head & w_mask) : ~^(w_head & w_mask));

  always_ff @(posedge CLK_I) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_next;
      if (fifo_reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // The counter restarts at every frame load so bit boundaries align to the load edge.
  assign w_tick = (r_state != S_IDLE) && (r_div != 16'd0) && (r_baud_cnt == 16'd0);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_baud_cnt <= '0;
    end else if (w_load) begin
      r_baud_cnt <= divisor - 16'd1;
    end else if (r_div != 16'd0) begin
      r_baud_cnt <= (r_baud_cnt == 16'd0) ? r_div - 16'd1 : r_baud_cnt - 16'd1;
    end
  end

  always_comb begin
    w_seg_ticks = 6'd16;
    if (r_state == S_STOP && r_lcr[2]) begin
      w_seg_ticks = (r_lcr[1:0] == 2'b00) ? 6'd24 : 6'd32;
    end
  end

  assign w_seg_done = w_tick && (r_tick_cnt == w_seg_ticks - 6'd1);
  assign w_last_bit = (r_bit_cnt == 3'd4 + {1'b0, r_lcr[1:0]});

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_tick_cnt <= '0;
    end else if (w_load || w_seg_done) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= r_tick_cnt + 6'd1;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_txd_next   = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0 && w_div_ok) begin
          w_load       = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_txd_next = 1'b0;
        if (w_seg_done) w_state_next = S_DATA;
      end
      S_DATA: begin
        w_txd_next = r_shift[0];
        if (w_seg_done && w_last_bit) w_state_next = r_lcr[3] ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_txd_next = r_parity;
        if (w_seg_done) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_seg_done) begin
          // Chain straight into the next frame so back-to-back bytes have no idle bit.
          if (r_count != '0 && w_div_ok) begin
            w_load       = 1'b1;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_shift   <= '0;
      r_lcr     <= '0;
      r_div     <= '0;
      r_parity  <= 1'b0;
      r_bit_cnt <= '0;
    end else if (w_load) begin
      r_shift   <= w_head;
      r_lcr     <= lcr[3:0];
      r_div     <= divisor;
      r_parity  <= w_head_parity;
      r_bit_cnt <= '0;
    end else if (r_state == S_DATA && w_seg_done) begin
      r_shift   <= {1'b0, r_shift[7:1]};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_full <= 1'b0;
      r_thre <= 1'b1;
      r_temt <= 1'b1;
      r_txd  <= 1'b1;
    end else begin
      r_full <= (w_count_next == DEPTH_C);
      r_thre <= (w_count_next == '0);
      r_temt <= (w_state_next == S_IDLE) && (w_count_next == '0);
      r_txd  <= w_txd_next;
    end
  end

  // Break overrides the line without disturbing the FSM.
  assign txd       = r_txd & ~lcr[6];
  assign fifo_full = r_full;
  assign thre      = r_thre;
  assign temt      = r_temt;

endmodule

// File: tb/tb_uart_8250_tx_engine.sv
// Bench for uart_8250_tx_engine: directed framing/FIFO/break/reset steps plus random frames,
// each frame compared clock by clock against a bit-list model built from the framing rules.
`timescale 1ns/1ps
module tb_uart_8250_tx_engine;

  localparam int WAIT_MAX = 3000;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic [15:0] divisor;
  logic [6:0]  lcr;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        fifo_reset;
  logic        fifo_full;
  logic        thre;
  logic        temt;
  logic        txd;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic       seg_lvl[$];
  int         seg_len[$];
  logic [6:0] cur_lcr;
  int         cur_div;

  uart_8250_tx_engine dut (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .divisor    (divisor),
    .lcr        (lcr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .fifo_reset (fifo_reset),
    .fifo_full  (fifo_full),
    .thre       (thre),
    .temt       (temt),
    .txd        (txd)
  );

  always #5 CLK_I = ~CLK_I;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [6:0] l, input int d);
    cur_lcr = l;
    cur_div = d;
    lcr     = l;
    divisor = 16'(d);
  endtask

  task automatic wr_byte(input logic [7:0] b, input bit accept);
    wr_data = b;
    wr_en   = 1'b1;
    @(posedge CLK_I);
    #1;
    wr_en = 1'b0;
    if (accept) exp_q.push_back(b);
  endtask

  // Expected line levels: start, 5..8 data bits LSB first, optional parity, stop.
  task automatic build_model(input logic [7:0] b, input logic [6:0] l, input int d);
    int   nb;
    int   ones;
    int   stop_ticks;
    logic p;
    seg_lvl.delete();
    seg_len.delete();
    nb   = 5 + int'(l[1:0]);
    ones = 0;
    seg_lvl.push_back(1'b0);
    seg_len.push_back(16 * d);
    for (int k = 0; k < nb; k++) begin
      seg_lvl.push_back(b[k]);
      seg_len.push_back(16 * d);
      ones += int'(b[k]);
    end
    if (l[3]) begin
      if (l[5])      p = ~l[4];
      else if (l[4]) p = (ones % 2 == 1);
      else           p = (ones % 2 == 0);
      seg_lvl.push_back(p);
      seg_len.push_back(16 * d);
    end
    if (!l[2])                stop_ticks = 16;
    else if (l[1:0] == 2'b00) stop_ticks = 24;
    else                      stop_ticks = 32;
    seg_lvl.push_back(1'b1);
    seg_len.push_back(stop_ticks * d);
  endtask

  // act_kind: 0 none, 1 break set at act_at and cleared 40 samples later,
  // 2 fifo_reset pulse at act_at, 3 asynchronous reset at act_at (frame abandoned).
  task automatic check_frame(input bit b2b, input int act_kind, input int act_at,
                             output int waited);
    logic [7:0] b;
    int         i;
    int         n_bad;
    bit         in_brk;
    waited = 0;
    i      = 0;
    in_brk = 0;
    @(negedge CLK_I);
    while (txd !== 1'b0 && waited < WAIT_MAX) begin
      waited++;
      @(negedge CLK_I);
    end
    chk("frame_start_timeout", (waited >= WAIT_MAX), 0);
    if (waited >= WAIT_MAX) return;
    if (b2b) chk("b2b_gap_clocks", waited, 0);
    chk("unexpected_frame", (exp_q.size() == 0), 0);
    if (exp_q.size() == 0) return;
    b = exp_q.pop_front();
    build_model(b, cur_lcr, cur_div);
    chk("temt_in_frame", temt, 0);
    for (int s = 0; s < seg_lvl.size(); s++) begin
      n_bad = 0;
      for (int k = 0; k < seg_len[s]; k++) begin
        if (i > 0) @(negedge CLK_I);
        if (act_kind == 3 && i == act_at) begin
          #2;
          RST_I = 1'b1;
          #1;
          chk("async_rst_txd", txd, 1);
          chk("async_rst_thre", thre, 1);
          chk("async_rst_temt", temt, 1);
          chk("async_rst_full", fifo_full, 0);
          @(negedge CLK_I);
          RST_I = 1'b0;
          exp_q.delete();
          return;
        end
        if (act_kind == 1 && i == act_at) begin
          lcr = cur_lcr | 7'h40;
          #1;
          chk("break_forces_low", txd, 0);
          in_brk = 1;
        end
        if (act_kind == 1 && i == act_at + 40) begin
          lcr = cur_lcr;
          #1;
          chk("break_release_bit", txd, seg_lvl[s]);
          in_brk = 0;
        end
        if (!in_brk && txd !== seg_lvl[s]) n_bad++;
        if (act_kind == 2 && i == act_at) begin
          fifo_reset = 1'b1;
          @(posedge CLK_I);
          #1;
          fifo_reset = 1'b0;
          chk("fifo_reset_thre", thre, 1);
          chk("fifo_reset_full", fifo_full, 0);
          exp_q.delete();
        end
        i++;
      end
      chk($sformatf("frame_b%02h_seg%0d_bad_samples", b, s), n_bad, 0);
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge CLK_I);
      if (txd !== 1'b1) bad++;
    end
    chk({tag, "_txd_high"}, bad, 0);
    chk({tag, "_temt"}, temt, 1);
    chk({tag, "_thre"}, thre, 1);
  endtask

  initial begin
    int         w;
    int         bad;
    int         rv;
    int         rd;
    logic [6:0] rl;
    logic [7:0] rb;

    set_cfg(7'h03, 1);
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    fifo_reset = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK_I);
    chk("rst_txd", txd, 1);
    chk("rst_thre", thre, 1);
    chk("rst_temt", temt, 1);
    chk("rst_full", fifo_full, 0);
    RST_I = 1'b0;
    @(negedge CLK_I);

    // 8N1, divisor 1, with load latency and flag timing
    wr_byte(8'h55, 1);
    chk("t1_thre_after_write", thre, 0);
    chk("t1_temt_after_write", temt, 0);
    @(posedge CLK_I);
    #1;
    chk("t1_thre_after_pop", thre, 1);
    chk("t1_temt_after_pop", temt, 0);
    check_frame(0, 0, 0, w);
    chk("t1_start_latency", w, 1);
    chk("t1_temt_at_stop_end", temt, 1);
    idle_check(20, "t1_idle");

    // 7-bit parity variants at divisor 3
    set_cfg(7'h1A, 3);
    wr_byte(8'h41, 1);
    check_frame(0, 0, 0, w);
    set_cfg(7'h0A, 3);
    wr_byte(8'h41, 1);
    check_frame(0, 0, 0, w);
    set_cfg(7'h2A, 3);
    wr_byte(8'h41, 1);
    check_frame(0, 0, 0, w);

    // Long stop bits
    set_cfg(7'h04, 1);
    wr_byte(8'h1F, 1);
    check_frame(0, 0, 0, w);
    set_cfg(7'h07, 1);
    wr_byte(8'hA7, 1);
    check_frame(0, 0, 0, w);
    idle_check(10, "t3_idle");

    // 17 writes from idle, then one dropped; frames back to back
    set_cfg(7'h03, 1);
    fork
      begin
        for (int k = 0; k < 17; k++) begin
          wr_byte(8'(k * 13 + 7), 1);
          if (k == 15) chk("t4_not_full_at_15", fifo_full, 0);
        end
        chk("t4_full", fifo_full, 1);
        wr_byte(8'hEE, 0);
        chk("t4_full_after_drop", fifo_full, 1);
      end
      begin
        check_frame(0, 0, 0, w);
        for (int k = 1; k < 17; k++) check_frame(1, 0, 0, w);
      end
    join
    idle_check(40, "t4a_idle");

    // 16 writes behind a frame in flight, then one dropped
    fork
      begin
        wr_byte(8'hC3, 1);
        repeat (3) @(posedge CLK_I);
        #1;
        chk("t4b_thre_in_flight", thre, 1);
        for (int k = 0; k < 16; k++) wr_byte(8'(k * 29 + 1), 1);
        chk("t4b_full", fifo_full, 1);
        wr_byte(8'h5A, 0);
        chk("t4b_full_after_drop", fifo_full, 1);
      end
      begin
        check_frame(0, 0, 0, w);
        for (int k = 1; k < 17; k++) check_frame(1, 0, 0, w);
      end
    join
    idle_check(40, "t4b_idle");

    // Break mid-frame
    set_cfg(7'h03, 1);
    wr_byte(8'h12, 1);
    check_frame(0, 1, 40, w);
    idle_check(10, "t5a_idle");

    // fifo_reset with queued bytes; current frame completes, the rest are discarded
    fork
      begin
        for (int k = 0; k < 6; k++) wr_byte(8'(8'h90 + k), 1);
      end
      begin
        check_frame(0, 2, 40, w);
      end
    join
    idle_check(40, "t5b_idle");

    // Asynchronous reset during data bits
    wr_byte(8'h00, 1);
    check_frame(0, 3, 40, w);
    idle_check(30, "t6a_idle");

    // divisor 0 stalls with data queued, then resumes
    set_cfg(7'h03, 0);
    wr_byte(8'h3C, 1);
    wr_byte(8'hC3, 1);
    bad = 0;
    repeat (100) begin
      @(negedge CLK_I);
      if (txd !== 1'b1) bad++;
    end
    chk("t6b_stall_txd", bad, 0);
    chk("t6b_stall_thre", thre, 0);
    chk("t6b_stall_temt", temt, 0);
    set_cfg(7'h03, 1);
    check_frame(0, 0, 0, w);
    check_frame(1, 0, 0, w);
    idle_check(10, "t6b_idle");

    // Random single frames
    repeat (6) begin
      rv = $urandom_range(0, 63);
      rl = 7'(rv);
      rd = $urandom_range(1, 3);
      rv = $urandom_range(0, 255);
      rb = 8'(rv);
      set_cfg(rl, rd);
      wr_byte(rb, 1);
      check_frame(0, 0, 0, w);
    end

    // Random back-to-back burst
    rv = $urandom_range(0, 63);
    rl = 7'(rv);
    rd = $urandom_range(1, 2);
    set_cfg(rl, rd);
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          rv = $urandom_range(0, 255);
          wr_byte(8'(rv), 1);
        end
      end
      begin
        check_frame(0, 0, 0, w);
        check_frame(1, 0, 0, w);
        check_frame(1, 0, 0, w);
      end
    join
    idle_check(20, "rand_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
